// File: rtl/mesh_edge_ni.sv
// mesh_edge_ni: host-to-mesh edge network interface with TX/RX first-word fall-through FIFOs.
module mesh_edge_ni_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

module mesh_edge_ni #(
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 4,
    parameter int X_EDGE      = 3,
    parameter int Y_EDGE      = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int FLIT_W      = 2*COORD_WIDTH+DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [COORD_WIDTH-1:0] tx_dst_x,
    input  logic [COORD_WIDTH-1:0] tx_dst_y,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    output logic                   tx_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLIT_W-1:0]      out_flit,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLIT_W-1:0]      in_flit,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [DATA_WIDTH-1:0]  rx_data,
    output logic [7:0]             drop_count,
    output logic [15:0]            tx_count,
    output logic [15:0]            rx_count
);
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic legal, tx_acc, tx_push, tx_pop, drop, rx_push, rx_pop;
    logic unused_dst;
    assign legal = (tx_dst_x != '0) && (tx_dst_x <= COORD_WIDTH'(X_EDGE)) &&
                   (tx_dst_y != '0) && (tx_dst_y <= COORD_WIDTH'(Y_EDGE));
    assign tx_ready  = !tx_full;
    assign tx_acc    = tx_valid && tx_ready;
    assign tx_push   = tx_acc && legal;
    assign drop      = tx_acc && !legal;
    assign out_valid = !tx_empty;
    assign tx_pop    = out_valid && out_ready;
    assign in_ready  = !rx_full;
    assign rx_push   = in_valid && in_ready;
    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_valid && rx_ready;
    // Only the payload is kept on the RX side; destination fields are ignored.
    assign unused_dst = ^in_flit[FLIT_W-1:DATA_WIDTH];

    mesh_edge_ni_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .din({tx_dst_x, tx_dst_y, tx_data}),
        .pop(tx_pop), .dout(out_flit), .full(tx_full), .empty(tx_empty)
    );

    mesh_edge_ni_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .din(in_flit[DATA_WIDTH-1:0]),
        .pop(rx_pop), .dout(rx_data), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_err     <= 1'b0;
            drop_count <= '0;
            tx_count   <= '0;
            rx_count   <= '0;
        end else begin
            tx_err <= drop;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            if (tx_pop) tx_count <= tx_count + 1'b1;
            if (rx_pop) rx_count <= rx_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mesh_edge_ni.sv
// tb_mesh_edge_ni: directed self-checking bench for mesh_edge_ni.
module tb_mesh_edge_ni;
    logic        clk = 0;
    logic        rst = 1;
    logic        tx_valid = 0;
    logic        tx_ready;
    logic [3:0]  tx_dst_x = 0;
    logic [3:0]  tx_dst_y = 0;
    logic [31:0] tx_data = 0;
    logic        tx_err;
    logic        out_valid;
    logic        out_ready = 0;
    logic [39:0] out_flit;
    logic        in_valid = 0;
    logic        in_ready;
    logic [39:0] in_flit = 0;
    logic        rx_valid;
    logic        rx_ready = 0;
    logic [31:0] rx_data;
    logic [7:0]  drop_count;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    int checks = 0;
    int failures = 0;

    mesh_edge_ni dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_data(tx_data), .tx_err(tx_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .drop_count(drop_count), .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL reset_tx_err got=%b exp=0", tx_err); end
        checks++; if ({drop_count, tx_count, rx_count} !== 40'd0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {drop_count, tx_count, rx_count}); end
    endtask

    task automatic test_single;
        out_ready = 1;
        tx_valid = 1; tx_dst_x = 2; tx_dst_y = 3; tx_data = 32'hDEADBEEF;
        @(negedge clk);
        tx_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_flit !== 40'h23DEADBEEF) begin failures++; $display("FAIL single_flit got=%h exp=23deadbeef", out_flit); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", out_valid); end
        checks++; if (tx_count !== 16'd1) begin failures++; $display("FAIL single_tx_count got=%0d exp=1", tx_count); end
    endtask

    task automatic test_tx_full;
        int k;
        logic acc;
        out_ready = 0;
        tx_dst_x = 1; tx_dst_y = 1;
        for (int i = 1; i <= 4; i++) begin
            tx_valid = 1; tx_data = 32'(i);
            #1;
            checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL full_ready_%0d got=%b exp=1", i, tx_ready); end
            @(negedge clk);
        end
        tx_data = 5;
        out_ready = 1;
        #1;
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%b exp=0", tx_ready); end
        k = 1;
        for (int c = 0; c < 20 && k <= 5; c++) begin
            if (out_valid) begin
                checks++; if (out_flit !== {4'd1, 4'd1, 32'(k)}) begin failures++; $display("FAIL full_order_%0d got=%h exp=%h", k, out_flit, {4'd1, 4'd1, 32'(k)}); end
                k++;
            end
            acc = tx_valid && tx_ready;
            @(negedge clk);
            if (acc) tx_valid = 0;
        end
        tx_valid = 0;
        checks++; if (k !== 6) begin failures++; $display("FAIL full_timeout got=%0d exp=6", k); end
        checks++; if (tx_count !== 16'd6) begin failures++; $display("FAIL full_tx_count got=%0d exp=6", tx_count); end
    endtask

    task automatic test_illegal;
        out_ready = 1;
        tx_valid = 1; tx_dst_x = 0; tx_dst_y = 1; tx_data = 32'h11;
        @(negedge clk);
        tx_valid = 0;
        checks++; if (tx_err !== 1'b1) begin failures++; $display("FAIL ill_err_a got=%b exp=1", tx_err); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_valid_a got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL ill_err_pulse got=%b exp=0", tx_err); end
        tx_valid = 1; tx_dst_x = 4; tx_dst_y = 1;
        @(negedge clk);
        tx_valid = 0;
        checks++; if (tx_err !== 1'b1) begin failures++; $display("FAIL ill_err_b got=%b exp=1", tx_err); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_valid_b got=%b exp=0", out_valid); end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL ill_drop2 got=%0d exp=2", drop_count); end
        tx_valid = 1; tx_dst_x = 1; tx_dst_y = 4;
        @(negedge clk);
        tx_valid = 0;
        checks++; if (tx_err !== 1'b1) begin failures++; $display("FAIL ill_err_y got=%b exp=1", tx_err); end
        tx_valid = 1; tx_dst_x = 3; tx_dst_y = 3; tx_data = 32'hCAFE0033;
        @(negedge clk);
        tx_valid = 0;
        checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL ill_edge_err got=%b exp=0", tx_err); end
        checks++; if (out_flit !== 40'h33CAFE0033 || out_valid !== 1'b1) begin failures++; $display("FAIL ill_edge_flit got=%h exp=33cafe0033", out_flit); end
        @(negedge clk);
        tx_valid = 1; tx_dst_x = 0; tx_dst_y = 0;
        repeat (300) @(negedge clk);
        tx_valid = 0;
        @(negedge clk);
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL ill_drop_sat got=%0d exp=255", drop_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_no_out got=%b exp=0", out_valid); end
        checks++; if (tx_count !== 16'd7) begin failures++; $display("FAIL ill_tx_count got=%0d exp=7", tx_count); end
    endtask

    task automatic test_rx;
        int in_idx;
        int out_idx;
        rx_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_flit = {4'hF, 4'hF, 32'hA0 + 32'(i)};
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rx_ready_%0d got=%b exp=1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rx_full got=%b exp=0", in_ready); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 32'hA0) begin failures++; $display("FAIL rx_head got=%h exp=a0", rx_data); end
        in_idx = 4;
        out_idx = 0;
        for (int c = 0; c < 100 && out_idx < 12; c++) begin
            rx_ready = c[0];
            in_valid = in_idx < 12;
            in_flit = {4'h5, 4'h6, 32'hA0 + 32'(in_idx)};
            #1;
            if (rx_valid && rx_ready) begin
                checks++; if (rx_data !== 32'hA0 + 32'(out_idx)) begin failures++; $display("FAIL rx_order_%0d got=%h exp=%h", out_idx, rx_data, 32'hA0 + 32'(out_idx)); end
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            @(negedge clk);
        end
        in_valid = 0; rx_ready = 0;
        checks++; if (out_idx !== 12) begin failures++; $display("FAIL rx_timeout got=%0d exp=12", out_idx); end
        checks++; if (rx_count !== 16'd12) begin failures++; $display("FAIL rx_count got=%0d exp=12", rx_count); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_empty got=%b exp=0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 0;
        tx_dst_x = 2; tx_dst_y = 2;
        for (int i = 0; i < 2; i++) begin
            tx_valid = 1; tx_data = 32'h100 + 32'(i);
            @(negedge clk);
        end
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            tx_valid = 1; tx_data = 32'h102 + 32'(i);
            #1;
            checks++; if (tx_ready !== 1'b1 || out_valid !== 1'b1 || out_flit !== {4'd2, 4'd2, 32'h100 + 32'(i)}) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, out_flit, {4'd2, 4'd2, 32'h100 + 32'(i)}); end
            @(negedge clk);
        end
        tx_valid = 0; out_ready = 0;
        checks++; if (out_flit !== {4'd2, 4'd2, 32'h10A}) begin failures++; $display("FAIL b2b_head got=%h exp=%h", out_flit, {4'd2, 4'd2, 32'h10A}); end
        checks++; if (tx_count !== 16'd17) begin failures++; $display("FAIL b2b_tx_count got=%0d exp=17", tx_count); end
        in_valid = 1; in_flit = 40'h11_0000_0BAD;
        @(negedge clk);
        in_valid = 0;
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_rx_loaded got=%b exp=1", rx_valid); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (out_valid !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b%b exp=00", out_valid, rx_valid); end
        checks++; if ({drop_count, tx_count, rx_count} !== 40'd0) begin failures++; $display("FAIL midrst_counters got=%h exp=0", {drop_count, tx_count, rx_count}); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b%b exp=11", tx_ready, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tx_full();
        test_illegal();
        test_rx();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
